// File: rtl/interleaver_if.sv
// Byte-stream interface for the QPP interleaver.
//   vld_crc/rdy_crc/cbs/data_in  : input side (from CRC-attach stage)
//   vld_out/rdy_out/last_byte/data_out : output side (to 2nd constituent encoder)
// master = stream source/sink around the block, slave = interleaver itself.
interface interleaver_if;
   logic       vld_crc;
   logic       rdy_crc;
   logic       cbs;
   logic [7:0] data_in;
   logic       vld_out;
   logic       rdy_out;
   logic       last_byte;
   logic [7:0] data_out;

   modport master (
      output vld_crc, cbs, data_in, rdy_out,
      input  rdy_crc, vld_out, last_byte, data_out
   );

   modport slave (
      input  vld_crc, cbs, data_in, rdy_out,
      output rdy_crc, vld_out, last_byte, data_out
   );
endinterface

// File: rtl/interleaver.sv
// LTE turbo QPP internal interleaver.
// Loads one K-bit code block byte-serially, then emits c'(i) = c(PI(i)),
// PI(i) = (f1*i + f2*i^2) mod K, byte-serially (bit 7 = earliest bit).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : interleaver_if.slave (input byte stream, output byte stream, cbs)
module interleaver #(
   parameter int K0   = 1056,
   parameter int F1_0 = 17,
   parameter int F2_0 = 66,
   parameter int K1   = 6144,
   parameter int F1_1 = 263,
   parameter int F2_1 = 480
) (
   input  logic            clk,
   input  logic            reset,
   interleaver_if.slave    bus
);

   localparam int AW = 13;
   localparam int NW = $clog2(K1 / 8);

   localparam logic [AW-1:0] G0_0  = AW'((F1_0 + F2_0) % K0);
   localparam logic [AW-1:0] G0_1  = AW'((F1_1 + F2_1) % K1);
   localparam logic [AW-1:0] D_0   = AW'((2 * F2_0) % K0);
   localparam logic [AW-1:0] D_1   = AW'((2 * F2_1) % K1);

   typedef enum logic [1:0] {IDLE, LOAD, GEN, SEND} state_t;

   state_t          state;
   logic [AW-1:0]   k;        // block size of current block
   logic [AW-1:0]   f2x2;     // 2*f2 mod K, step of g
   logic [AW-1:0]   pi;       // PI(i)
   logic [AW-1:0]   g;        // PI(i+1) - PI(i) mod K
   logic [AW-1:0]   i;        // output bit index
   logic [NW-1:0]   n;        // input byte address
   logic [6:0]      asm_q;    // first 7 bits of the byte being assembled

   logic            mem [K1];

   logic [AW:0]     pi_sum, g_sum;
   logic [AW-1:0]   pi_nx, g_nx;
   logic            bit_rd;
   logic            n_last;

   // Incremental QPP: each mod K is a single conditional subtract since
   // both addends are already reduced.
   always_comb begin
      pi_sum = {1'b0, pi} + {1'b0, g};
      g_sum  = {1'b0, g} + {1'b0, f2x2};
      pi_nx  = (pi_sum >= {1'b0, k}) ? AW'(pi_sum - {1'b0, k}) : pi_sum[AW-1:0];
      g_nx   = (g_sum  >= {1'b0, k}) ? AW'(g_sum  - {1'b0, k}) : g_sum[AW-1:0];
      bit_rd = mem[pi];
      n_last = (n == NW'((k >> 3) - 1'b1));
   end

   // Bit buffer: byte write, bit read. Not reset; a new block overwrites it.
   always_ff @(posedge clk) begin
      if (state == LOAD && bus.vld_crc) begin
         for (int j = 0; j < 8; j++)
            mem[{n, 3'(j)}] <= bus.data_in[7-j];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         k             <= '0;
         f2x2          <= '0;
         pi            <= '0;
         g             <= '0;
         i             <= '0;
         n             <= '0;
         asm_q         <= '0;
         bus.rdy_crc   <= 1'b0;
         bus.vld_out   <= 1'b0;
         bus.last_byte <= 1'b0;
         bus.data_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.vld_crc) begin
                  k           <= bus.cbs ? AW'(K1) : AW'(K0);
                  f2x2        <= bus.cbs ? D_1 : D_0;
                  g           <= bus.cbs ? G0_1 : G0_0;
                  pi          <= '0;
                  i           <= '0;
                  n           <= '0;
                  bus.rdy_crc <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (bus.vld_crc) begin
                  n <= n + 1'b1;
                  if (n_last) begin
                     bus.rdy_crc <= 1'b0;
                     state       <= GEN;
                  end
               end
            end
            GEN: begin
               i  <= i + 1'b1;
               pi <= pi_nx;
               g  <= g_nx;
               if (i[2:0] == 3'd7) begin
                  bus.data_out  <= {asm_q, bit_rd};
                  bus.vld_out   <= 1'b1;
                  bus.last_byte <= (i == k - 1'b1);
                  state         <= SEND;
               end else begin
                  asm_q <= {asm_q[5:0], bit_rd};
               end
            end
            SEND: begin
               if (bus.rdy_out) begin
                  bus.vld_out <= 1'b0;
                  if (bus.last_byte) begin
                     bus.last_byte <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     state <= GEN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interleaver.sv
// Scoreboard bench for the QPP interleaver: expected bytes come from a
// direct-formula model and are queued when a block is driven.
module tb_interleaver;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   interleaver_if bus ();
   interleaver dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];
   bit         inb   [6144];
   logic [7:0] bytes [768];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_rdy_crc"}, 32'(bus.rdy_crc), 0);
      chk({tag, "_vld_out"}, 32'(bus.vld_out), 0);
      chk({tag, "_last"},    32'(bus.last_byte), 0);
      chk({tag, "_data"},    32'(bus.data_out), 0);
   endtask

   // abort: 0 = full block, 1 = reset after 50 bytes loaded, 2 = reset at first vld_out
   task automatic run_block(input bit cbs_v, input int one_bit, input int exp0,
                            input bit gaps, input bit bp, input int abort);
      longint k, f1, f2, p, idx;
      int nb, n, cyc, outn;
      bit v, acc, held;
      logic [7:0] e, d;
      k  = cbs_v ? 6144 : 1056;
      f1 = cbs_v ? 263 : 17;
      f2 = cbs_v ? 480 : 66;
      nb = int'(k / 8);
      for (int b = 0; b < int'(k); b++)
         inb[b] = (one_bit < 0) ? 1'($urandom_range(0, 1)) : (b == one_bit);
      for (int m = 0; m < nb; m++)
         for (int j = 0; j < 8; j++) bytes[m][7-j] = inb[8*m+j];
      exp_q.delete();
      for (int m = 0; m < nb; m++) begin
         for (int j = 0; j < 8; j++) begin
            idx = 8 * m + j;
            p = (f1 * idx + f2 * idx * idx) % k;
            e[7-j] = inb[int'(p)];
         end
         exp_q.push_back(e);
      end

      // load phase (starts and ends at a negedge)
      @(negedge clk);
      bus.cbs = cbs_v;
      n = 0; cyc = 0;
      while (n < nb && cyc < 20000) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.vld_crc = v;
         bus.data_in = bytes[n];
         acc = v && bus.rdy_crc;
         @(posedge clk);
         if (acc) begin
            n++;
            bus.cbs = ~cbs_v;   // must be ignored once the block started
         end
         cyc++;
         @(negedge clk);
         if (abort == 1 && n == 50) begin
            bus.vld_crc = 1'b0;
            reset = 1'b0;
            #1 chk_rst("rst_load");
            @(negedge clk);
            reset = 1'b1;
            exp_q.delete();
            return;
         end
      end
      bus.vld_crc = 1'b0;
      if (n < nb) chk("load_timeout", 32'(n), 32'(nb));

      // output phase
      outn = 0; cyc = 0; held = 0;
      while (outn < nb && cyc < 40000) begin
         if (bus.vld_out) begin
            if (abort == 2) begin
               reset = 1'b0;
               #1 chk_rst("rst_send");
               @(negedge clk);
               reset = 1'b1;
               bus.rdy_out = 1'b0;
               exp_q.delete();
               return;
            end
            if (bp && outn == 3 && !held) begin
               held = 1;
               bus.rdy_out = 1'b0;
               d = bus.data_out;
               for (int c = 0; c < 20; c++) begin
                  @(negedge clk);
                  chk("bp_vld", 32'(bus.vld_out), 1);
                  chk("bp_data", 32'(bus.data_out), 32'(d));
               end
            end
            bus.rdy_out = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.rdy_out) begin
               if (exp_q.size() == 0) chk("underflow", 32'(outn), 32'(nb));
               else begin
                  e = exp_q.pop_front();
                  chk("data", 32'(bus.data_out), 32'(e));
               end
               chk("last", 32'(bus.last_byte), 32'(outn == nb - 1));
               if (outn == 0 && exp0 >= 0) chk("byte0", 32'(bus.data_out), 32'(exp0));
               outn++;
            end
         end else begin
            bus.rdy_out = 1'($urandom_range(0, 1));   // ignored while vld_out=0
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      bus.rdy_out = 1'b0;
      chk("nbytes", 32'(outn), 32'(nb));
      chk("q_empty", 32'(exp_q.size()), 0);
      chk("end_vld", 32'(bus.vld_out), 0);
      chk("end_last", 32'(bus.last_byte), 0);
      chk("end_rdy_crc", 32'(bus.rdy_crc), 0);
   endtask

   initial begin
      bit seen;
      bus.vld_crc = 1'b1;
      bus.rdy_out = 1'b0;
      bus.cbs     = 1'b0;
      bus.data_in = 8'h00;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk_rst("reset");
      reset = 1'b1;
      seen = 0;
      for (int c = 0; c < 2 && !seen; c++) begin
         @(posedge clk);
         @(negedge clk);
         seen = bus.rdy_crc;
      end
      chk("rdy_after_rst", 32'(seen), 1);
      bus.vld_crc = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      run_block(1'b0, 83,  8'h40, 0, 0, 0);
      run_block(1'b0, 0,   8'h80, 0, 0, 0);
      run_block(1'b0, 298, 8'h20, 0, 0, 0);
      run_block(1'b0, 645, 8'h10, 0, 0, 0);
      run_block(1'b1, 743, 8'h40, 0, 0, 0);
      run_block(1'b0, -1,  -1,    1, 1, 0);
      run_block(1'b0, -1,  -1,    0, 0, 1);
      run_block(1'b0, -1,  -1,    1, 0, 0);
      run_block(1'b0, -1,  -1,    0, 0, 2);
      run_block(1'b0, -1,  -1,    0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/interleaver.md
Name: interleaver

Overview:
- LTE turbo-encoder QPP internal interleaver. Byte-serial input from the CRC-attach stage; byte-serial interleaved block output to the second constituent encoder.
- Buffers one code block of K bits and emits c'(i) = c(Π(i)), with Π(i) = (f1·i + f2·i²) mod K.
- Supports two block sizes: K=1056 (f1=17, f2=66) and K=6144 (f1=263, f2=480), selected by cbs.

Parameters:
- K0, 1056, block size when cbs=0
- F1_0, 17, QPP f1 for K0
- F2_0, 66, QPP f2 for K0
- K1, 6144, block size when cbs=1
- F1_1, 263, QPP f1 for K1
- F2_1, 480, QPP f2 for K1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- vld_crc  in  1  upstream has a valid input byte on data_in
- rdy_out  in  1  downstream accepts data_out
- cbs  in  1  block-size select: 0 = K0, 1 = K1
- data_in  in  8  input byte; bit 7 is the earlier bit in the stream
- rdy_crc  out  1  block ready to accept input bytes
- vld_out  out  1  data_out holds a valid interleaved byte
- last_byte  out  1  current output byte is the final byte of the block
- data_out  out  8  interleaved byte; bit 7 is the earlier bit in the stream

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rdy_crc, vld_out and last_byte = 0; data_out = 0; all counters = 0. Asserting reset mid-block aborts the block and discards buffered data.
- Bit order: stream bit c(8n+j) = data_in[7-j] of input byte n. Output bit c'(8n+j) = data_out[7-j] of output byte n.
- IDLE: rdy_crc = 0. On a clock edge with vld_crc=1, latch cbs (K, f1, f2 are fixed for the whole block) and move to LOAD.
- LOAD: rdy_crc = 1.
  - Each edge with vld_crc & rdy_crc writes data_in into the bit buffer at byte address n, then n increments.
  - After byte K/8-1 is written (byte 131 for K0, byte 767 for K1), rdy_crc drops to 0 on the same edge; go to GEN.
  - Edges with vld_crc=0 in LOAD do nothing.
- GEN: read one bit per cycle at address Π(i), shifting it into an 8-bit assembly register MSB-first; i counts 0..K-1.
  - Π is computed incrementally, with no multipliers: Π(0)=0, g(0)=(f1+f2) mod K, Π(i+1)=(Π(i)+g(i)) mod K, g(i+1)=(g(i)+2·f2) mod K.
  - Each mod is one conditional subtract; all operands are < K and 13 bits wide.
  - After 8 bits are assembled, load data_out, set vld_out=1 and go to SEND.
- SEND: data_out and vld_out are held stable until an edge with rdy_out=1.
  - On that edge, vld_out drops to 0.
  - If more bits remain, return to GEN; otherwise clear last_byte and go to IDLE.
  - last_byte = 1 exactly while the final byte (i = K-8..K-1) is presented.
- Throughput: one output byte per 9 cycles or more. Latency from the last input byte to the first vld_out is 9 cycles.
- The bit buffer is K1 bits deep. It may be built as a 1-bit-read / 8-bit-write RAM or as a register array.
- cbs changes outside IDLE are ignored. vld_crc is ignored outside IDLE/LOAD. rdy_out is ignored when vld_out=0.
- A new block may start only after returning to IDLE; back-to-back blocks are allowed.

Test Plan:
- Reset held low with vld_crc=1 -> rdy_crc=0, vld_out=0, last_byte=0, data_out=0. Release reset -> rdy_crc=1 within 2 cycles.
- cbs=0; input bit 83 = 1, all other bits 0 (byte 10 = 0x10); rdy_out=1 -> first output byte = 0x40 (c'(1)=c(83)). All other 131 output bytes = 0x00. last_byte is high only on output byte 131.
- cbs=0; input bit 0 = 1 only (byte 0 = 0x80) -> output byte 0 = 0x80. Input bit 298 = 1 only -> output byte 0 = 0x20. Input bit 645 = 1 only -> output byte 0 = 0x10.
- cbs=1, 768 bytes; input bit 743 = 1 only -> output byte 0 = 0x40. Exactly 768 vld_out handshakes occur; last_byte accompanies the 768th.
- Backpressure: rdy_out held 0 for 20 cycles during SEND -> data_out and vld_out are stable throughout; no byte is lost or duplicated. Gaps in vld_crc during LOAD -> output identical to the gap-free case.
- Reset asserted mid-LOAD and mid-SEND -> immediate return to reset values. A following full block is processed correctly.
